mac_share_arbiter: RTL and testbench
====================================

MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 Parameter: MAC_LAT, default 1, cycles from mac_a/b/c register update to mac_out sampling; legal range 1..4.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: resetb  in  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid  in  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b, req0_c  in  18 each  requester 0 operands.
REQ-007 Port: req1_valid, req1_ready, req1_a, req1_b, req1_c; same as REQ-004..006 for requester 1.
REQ-008 Port: mac_a, mac_b, mac_c  out  18 each  registered operands to the shared DSP18 MAC.
REQ-009 Port: mac_out  in  18  DSP18 MAC result, (a*b+c) mod 2^18.
REQ-010 Port: rsp_valid  out  1  result available.
REQ-011 Port: rsp_ready  in  1  consumer accepts result.
REQ-012 Port: rsp_id  out  1  requester that owns the result.
REQ-013 Port: rsp_data  out  18  captured MAC result.
REQ-014 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, with one operation in flight at most.
REQ-016 In IDLE the grant SHALL be: only one valid, grant it; both valid, grant the requester not equal to last_grant; none valid, no grant.
REQ-017 reqN_ready SHALL be combinational and high only when state is IDLE and requester N is granted; it SHALL be low in WAIT and RESP.
REQ-018 On an accept edge (valid & ready), the block SHALL load mac_a/b/c from the granted operands, store the requester in the id register, set lat_cnt = MAC_LAT, and go to WAIT.
REQ-019 In WAIT, lat_cnt SHALL decrement each edge; on the edge where lat_cnt == 1, the block SHALL capture mac_out into rsp_data, set rsp_valid and go to RESP.
REQ-020 Latency: for an accept at edge k, rsp_valid SHALL first be high after edge k+MAC_LAT.
REQ-021 In RESP, rsp_valid, rsp_id and rsp_data SHALL be held stable until an edge with rsp_ready high.
REQ-022 On the rsp handshake edge, the block SHALL clear rsp_valid, set last_grant = rsp_id and return to IDLE.
REQ-023 The earliest next accept SHALL be one cycle after the handshake; sustained throughput is one operation per MAC_LAT+2 cycles.
REQ-024 mac_a/b/c SHALL change only on accept edges and hold their values otherwise.
REQ-025 Requester valid/operand changes while not granted SHALL have no effect; a requester's valid deasserted before accept SHALL be treated as withdrawn, with no error.
REQ-026 The block SHALL do no arithmetic on the data; widths SHALL pass through at 18 bits unchanged.
REQ-027 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-028 On resetb low, asynchronously: state = IDLE, lat_cnt = 0, mac_a/b/c = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, last_grant = 1 (requester 0 wins the first contention).
REQ-029 Reset asserted in WAIT or RESP SHALL discard the in-flight operation, with no response produced after release.
REQ-030 After resetb deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 Bench SHALL model the DSP as mac_out = (mac_a*mac_b+mac_c) mod 2^18, delayed by MAC_LAT-1 register stages.
REQ-032 Scenario single: MAC_LAT=1, req0 {a=3,b=5,c=7}, rsp_ready=1 -> req0_ready high in cycle 0; rsp_valid after edge 1; rsp_id=0; rsp_data=22; busy low two cycles after accept.
REQ-033 Scenario contention: both valid continuously after reset, req0 {2,2,0}, req1 {4,4,1} -> grant order 0,1,0,1; responses 4,17,4,17 with alternating rsp_id.
REQ-034 Scenario backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable; both reqN_ready low; req1 accepted only one cycle after rsp_ready rises.
REQ-035 Scenario wrap/latency: MAC_LAT=3, req1 {a=18'h3FFFF,b=2,c=5} -> rsp_data=18'h00003 exactly 3 edges after accept.
REQ-036 Scenario reset mid-op: resetb low during WAIT -> all outputs at REQ-028 values immediately; no rsp_valid after release; next req0 accepted normally.

Source files
------------

// File: rtl/mac_share_arbiter_if.sv
// Bundle of the two requester ports, the shared MAC operand/result path and the
// response port of the shared-MAC arbiter.
interface mac_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [17:0] req0_a;
  logic [17:0] req0_b;
  logic [17:0] req0_c;
  logic        req1_valid;
  logic        req1_ready;
  logic [17:0] req1_a;
  logic [17:0] req1_b;
  logic [17:0] req1_c;
  logic [17:0] mac_a;
  logic [17:0] mac_b;
  logic [17:0] mac_c;
  logic [17:0] mac_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [17:0] rsp_data;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    input  req1_valid, req1_a, req1_b, req1_c,
    input  mac_out, rsp_ready,
    output req0_ready, req1_ready,
    output mac_a, mac_b, mac_c,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    output req1_valid, req1_a, req1_b, req1_c,
    output mac_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  mac_a, mac_b, mac_c,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mac_share_arbiter.sv
// Two-requester round-robin arbiter for one shared DSP18 MAC; one operation in
// flight, result captured MAC_LAT cycles after the operands are registered.
//
// state | meaning
// IDLE  | waiting for a request, grant is combinational
// WAIT  | operands on the MAC, counting down the MAC latency
// RESP  | result held on rsp_* until the consumer takes it
module mac_share_arbiter #(
  parameter int MAC_LAT = 1
) (
  input logic               clk,
  input logic               resetb,
  mac_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_lat_cnt;
  logic        r_last_grant;
  logic        r_id;
  logic        r_rsp_valid;
  logic [17:0] r_rsp_data;
  logic [17:0] r_mac_a;
  logic [17:0] r_mac_b;
  logic [17:0] r_mac_c;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_capture;
  logic        w_release;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // On contention the requester that did not own the last result wins.
  always_comb begin
    w_grant0    = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    w_grant1    = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_grant0 | w_grant1) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (r_lat_cnt == 3'd1) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: if (bus.rsp_ready) begin
        w_release   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_lat_cnt    <= 3'd0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 18'd0;
      r_mac_a      <= 18'd0;
      r_mac_b      <= 18'd0;
      r_mac_c      <= 18'd0;
    end else begin
      if (w_accept) begin
        r_mac_a   <= w_grant1 ? bus.req1_a : bus.req0_a;
        r_mac_b   <= w_grant1 ? bus.req1_b : bus.req0_b;
        r_mac_c   <= w_grant1 ? bus.req1_c : bus.req0_c;
        r_id      <= w_grant1;
        r_lat_cnt <= 3'(MAC_LAT);
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end
      if (w_capture) begin
        r_rsp_data  <= bus.mac_out;
        r_rsp_valid <= 1'b1;
      end
      if (w_release) begin
        r_rsp_valid  <= 1'b0;
        r_last_grant <= r_id;
      end
    end
  end

  assign bus.req0_ready = (r_state == ST_IDLE) & w_grant0;
  assign bus.req1_ready = (r_state == ST_IDLE) & w_grant1;
  assign bus.mac_a      = r_mac_a;
  assign bus.mac_b      = r_mac_b;
  assign bus.mac_c      = r_mac_c;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Scoreboard bench for mac_share_arbiter: one instance at MAC_LAT=1, one at
// MAC_LAT=3, each driving a behavioural DSP18 MAC model.
module tb_mac_share_arbiter;

  logic clk = 1'b0;
  logic resetb;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mac_share_arbiter_if if1 ();
  mac_share_arbiter_if if3 ();

  mac_share_arbiter #(.MAC_LAT(1)) u_dut1 (.clk(clk), .resetb(resetb), .bus(if1));
  mac_share_arbiter #(.MAC_LAT(3)) u_dut3 (.clk(clk), .resetb(resetb), .bus(if3));

  function automatic logic [17:0] dsp(input logic [17:0] a, input logic [17:0] b,
                                      input logic [17:0] c);
    logic [35:0] t;
    t = {18'd0, a} * {18'd0, b} + {18'd0, c};
    return t[17:0];
  endfunction

  // MAC model: MAC_LAT-1 register stages after the operand registers
  logic [17:0] p3_s1, p3_s2;
  always @(posedge clk) begin
    p3_s1 <= dsp(if3.mac_a, if3.mac_b, if3.mac_c);
    p3_s2 <= p3_s1;
  end
  assign if3.mac_out = p3_s2;
  assign if1.mac_out = dsp(if1.mac_a, if1.mac_b, if1.mac_c);

  typedef struct packed {
    logic        id;
    logic [17:0] data;
  } exp_t;
  exp_t sb_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    if1.req0_valid = 0; if1.req0_a = 0; if1.req0_b = 0; if1.req0_c = 0;
    if1.req1_valid = 0; if1.req1_a = 0; if1.req1_b = 0; if1.req1_c = 0;
    if1.rsp_ready  = 0;
    if3.req0_valid = 0; if3.req0_a = 0; if3.req0_b = 0; if3.req0_c = 0;
    if3.req1_valid = 0; if3.req1_a = 0; if3.req1_b = 0; if3.req1_c = 0;
    if3.rsp_ready  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  // Called just after an accept edge; counts edges until rsp_valid is seen.
  task automatic wait_rsp1(output int n);
    n = 0;
    while (!if1.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rsp3(output int n);
    n = 0;
    while (!if3.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    resetb = 1'b0;
    #1;
    checks++;
    if ({if1.mac_a, if1.mac_b, if1.mac_c, if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.busy} !== 76'd0) begin
      failures++;
      $display("FAIL reset_lat1: got=%0h exp=0",
               {if1.mac_a, if1.mac_b, if1.mac_c, if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.busy});
    end
    checks++;
    if ({if3.mac_a, if3.mac_b, if3.mac_c, if3.rsp_valid, if3.rsp_id, if3.rsp_data, if3.busy} !== 76'd0) begin
      failures++;
      $display("FAIL reset_lat3: got=%0h exp=0",
               {if3.mac_a, if3.mac_b, if3.mac_c, if3.rsp_valid, if3.rsp_id, if3.rsp_data, if3.busy});
    end
    @(negedge clk);
    // request already pending at release must be accepted on the first edge
    if1.req0_a = 18'd1; if1.req0_b = 18'd2; if1.req0_c = 18'd3; if1.req0_valid = 1;
    if1.rsp_ready = 1;
    sb_q.push_back('{id: 1'b0, data: 18'd5});
    resetb = 1'b1;
    #1;
    checks++;
    if (if1.req0_ready !== 1'b1) begin
      failures++; $display("FAIL reset_first_ready: got=%0b exp=1", if1.req0_ready);
    end
    @(negedge clk);
    if1.req0_valid = 0;
    checks++;
    if ({if1.busy, if1.mac_a} !== {1'b1, 18'd1}) begin
      failures++; $display("FAIL reset_first_accept: got=%0h exp=%0h", {if1.busy, if1.mac_a}, {1'b1, 18'd1});
    end
    begin
      int n;
      exp_t e;
      wait_rsp1(n);
      e = sb_q.pop_front();
      checks++;
      if ({if1.rsp_valid, if1.rsp_id, if1.rsp_data} !== {1'b1, e.id, e.data}) begin
        failures++; $display("FAIL reset_first_rsp: got=%0h exp=%0h", {if1.rsp_valid, if1.rsp_id, if1.rsp_data}, {1'b1, e.id, e.data});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    exp_t e;
    do_reset();
    if1.req0_a = 18'd3; if1.req0_b = 18'd5; if1.req0_c = 18'd7; if1.req0_valid = 1;
    if1.rsp_ready = 1;
    sb_q.push_back('{id: 1'b0, data: 18'd22});
    #1;
    checks++;
    if ({if1.req0_ready, if1.req1_ready} !== 2'b10) begin
      failures++; $display("FAIL single_ready: got=%0b exp=10", {if1.req0_ready, if1.req1_ready});
    end
    @(negedge clk);
    if1.req0_valid = 0;
    checks++;
    if ({if1.mac_a, if1.mac_b, if1.mac_c} !== {18'd3, 18'd5, 18'd7}) begin
      failures++; $display("FAIL single_mac_ops: got=%0h exp=%0h", {if1.mac_a, if1.mac_b, if1.mac_c}, {18'd3, 18'd5, 18'd7});
    end
    checks++;
    if ({if1.busy, if1.req0_ready} !== 2'b10) begin
      failures++; $display("FAIL single_wait: got=%0b exp=10", {if1.busy, if1.req0_ready});
    end
    wait_rsp1(n);
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL single_latency: got=%0d exp=1", n);
    end
    e = sb_q.pop_front();
    checks++;
    if ({if1.rsp_id, if1.rsp_data} !== {e.id, e.data}) begin
      failures++; $display("FAIL single_rsp: got=%0h exp=%0h", {if1.rsp_id, if1.rsp_data}, {e.id, e.data});
    end
    @(negedge clk);
    checks++;
    if ({if1.busy, if1.rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL single_done: got=%0b exp=00", {if1.busy, if1.rsp_valid});
    end
  endtask

  task automatic test_contention();
    int gq[$];
    int grants = 0;
    int cyc = 0;
    exp_t e;
    do_reset();
    if1.req0_a = 18'd2; if1.req0_b = 18'd2; if1.req0_c = 18'd0; if1.req0_valid = 1;
    if1.req1_a = 18'd4; if1.req1_b = 18'd4; if1.req1_c = 18'd1; if1.req1_valid = 1;
    if1.rsp_ready = 1;
    gq = '{0, 1, 0, 1};
    sb_q.push_back('{id: 1'b0, data: 18'd4});
    sb_q.push_back('{id: 1'b1, data: 18'd17});
    sb_q.push_back('{id: 1'b0, data: 18'd4});
    sb_q.push_back('{id: 1'b1, data: 18'd17});
    while ((grants < 4 || sb_q.size() > 0) && cyc < 40) begin
      if (grants == 4) begin
        if1.req0_valid = 0; if1.req1_valid = 0;
      end
      #1;
      if ((if1.req0_ready | if1.req1_ready) && gq.size() > 0) begin
        int g;
        g = gq.pop_front();
        grants++;
        checks++;
        if ({if1.req0_ready, if1.req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL contention_grant%0d: got=%0b exp_req=%0d", grants, {if1.req0_ready, if1.req1_ready}, g);
        end
      end
      if (if1.rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL contention_extra_rsp: got=%0h exp=none", if1.rsp_data);
        end else begin
          e = sb_q.pop_front();
          if ({if1.rsp_id, if1.rsp_data} !== {e.id, e.data}) begin
            failures++; $display("FAIL contention_rsp: got=%0h exp=%0h", {if1.rsp_id, if1.rsp_data}, {e.id, e.data});
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    if1.req0_valid = 0; if1.req1_valid = 0;
    checks++;
    if (grants != 4 || sb_q.size() != 0) begin
      failures++; $display("FAIL contention_timeout: got=grants%0d/pending%0d exp=4/0", grants, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    logic [18:0] hold;
    do_reset();
    if1.req0_a = 18'd1; if1.req0_b = 18'd1; if1.req0_c = 18'd1; if1.req0_valid = 1;
    if1.rsp_ready = 0;
    sb_q.push_back('{id: 1'b0, data: 18'd2});
    @(negedge clk);
    if1.req0_valid = 0;
    if1.req1_a = 18'd6; if1.req1_b = 18'd7; if1.req1_c = 18'd8; if1.req1_valid = 1;
    sb_q.push_back('{id: 1'b1, data: 18'd50});
    wait_rsp1(n);
    e = sb_q.pop_front();
    checks++;
    if ({if1.rsp_id, if1.rsp_data} !== {e.id, e.data}) begin
      failures++; $display("FAIL bp_rsp0: got=%0h exp=%0h", {if1.rsp_id, if1.rsp_data}, {e.id, e.data});
    end
    hold = {e.id, e.data};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.mac_a} !== {1'b1, hold, 18'd1}) begin
        failures++; $display("FAIL bp_hold%0d: got=%0h exp=%0h", i, {if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.mac_a}, {1'b1, hold, 18'd1});
      end
      checks++;
      if ({if1.req0_ready, if1.req1_ready} !== 2'b00) begin
        failures++; $display("FAIL bp_ready_low%0d: got=%0b exp=00", i, {if1.req0_ready, if1.req1_ready});
      end
    end
    if1.rsp_ready = 1;
    #1;
    checks++;
    if (if1.req1_ready !== 1'b0) begin
      failures++; $display("FAIL bp_ready_same_cycle: got=%0b exp=0", if1.req1_ready);
    end
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, if1.req1_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_ready_next_cycle: got=%0b exp=01", {if1.rsp_valid, if1.req1_ready});
    end
    @(negedge clk);
    if1.req1_valid = 0;
    wait_rsp1(n);
    e = sb_q.pop_front();
    checks++;
    if ({n[4:0], if1.rsp_id, if1.rsp_data} !== {5'd1, e.id, e.data}) begin
      failures++; $display("FAIL bp_rsp1: got=%0h exp=%0h", {n[4:0], if1.rsp_id, if1.rsp_data}, {5'd1, e.id, e.data});
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    exp_t e;
    do_reset();
    if3.req1_a = 18'h3FFFF; if3.req1_b = 18'd2; if3.req1_c = 18'd5; if3.req1_valid = 1;
    if3.rsp_ready = 1;
    sb_q.push_back('{id: 1'b1, data: 18'h00003});
    #1;
    checks++;
    if ({if3.req0_ready, if3.req1_ready} !== 2'b01) begin
      failures++; $display("FAIL wrap_ready: got=%0b exp=01", {if3.req0_ready, if3.req1_ready});
    end
    @(negedge clk);
    if3.req1_valid = 0;
    checks++;
    if (if3.mac_a !== 18'h3FFFF) begin
      failures++; $display("FAIL wrap_mac_a: got=%0h exp=3ffff", if3.mac_a);
    end
    wait_rsp3(n);
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL wrap_latency: got=%0d exp=3", n);
    end
    e = sb_q.pop_front();
    checks++;
    if ({if3.rsp_id, if3.rsp_data} !== {e.id, e.data}) begin
      failures++; $display("FAIL wrap_rsp: got=%0h exp=%0h", {if3.rsp_id, if3.rsp_data}, {e.id, e.data});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int n;
    int seen = 0;
    exp_t e;
    do_reset();
    if3.req0_a = 18'd3; if3.req0_b = 18'd5; if3.req0_c = 18'd7; if3.req0_valid = 1;
    if3.rsp_ready = 1;
    @(negedge clk);
    if3.req0_valid = 0;
    @(negedge clk);
    checks++;
    if (if3.busy !== 1'b1) begin
      failures++; $display("FAIL midop_busy: got=%0b exp=1", if3.busy);
    end
    resetb = 1'b0;
    #1;
    checks++;
    if ({if3.mac_a, if3.mac_b, if3.mac_c, if3.rsp_valid, if3.rsp_id, if3.rsp_data, if3.busy} !== 76'd0) begin
      failures++; $display("FAIL midop_reset_vals: got=%0h exp=0",
                           {if3.mac_a, if3.mac_b, if3.mac_c, if3.rsp_valid, if3.rsp_id, if3.rsp_data, if3.busy});
    end
    @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if3.rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midop_stale_rsp: got=%0d exp=0", seen);
    end
    if3.req0_a = 18'd2; if3.req0_b = 18'd3; if3.req0_c = 18'd4; if3.req0_valid = 1;
    sb_q.push_back('{id: 1'b0, data: 18'd10});
    #1;
    checks++;
    if (if3.req0_ready !== 1'b1) begin
      failures++; $display("FAIL midop_next_ready: got=%0b exp=1", if3.req0_ready);
    end
    @(negedge clk);
    if3.req0_valid = 0;
    wait_rsp3(n);
    e = sb_q.pop_front();
    checks++;
    if ({n[4:0], if3.rsp_id, if3.rsp_data} !== {5'd3, e.id, e.data}) begin
      failures++; $display("FAIL midop_next_rsp: got=%0h exp=%0h", {n[4:0], if3.rsp_id, if3.rsp_data}, {5'd3, e.id, e.data});
    end
    @(negedge clk);
  endtask

  initial begin
    resetb = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
